// File: rtl/uart_tx_mmio_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_tx_mmio_if
// Description : Store-path bus and serial-side signals of the memory-mapped
//               UART transmitter.
//               Master drives stores. Slave returns status, txd and busy.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_mmio_if;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        txd;
    logic        busy;

    modport master (
        output we,
        output addr,
        output wdata,
        input  rdata,
        input  txd,
        input  busy
    );

    modport slave (
        input  we,
        input  addr,
        input  wdata,
        output rdata,
        output txd,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_mmio.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_tx_mmio
// Description : Memory-mapped 8N1 UART transmitter.
//               A store to TX_ADDR queues a byte in a FIFO.
//               A store to STAT_ADDR with bit 2 set clears the sticky overflow flag.
//               A read of STAT_ADDR returns {overflow, full, busy}.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_mmio #(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] TX_ADDR      = 32'h0000_F000,
    parameter logic [31:0] STAT_ADDR    = 32'h0000_F004
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_mmio_if.slave bus
);

    localparam int c_BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W  = c_PTR_W + 1;
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0]  c_DEPTH     = c_CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_overflow;

    // Serialiser state
    state_t              r_state;
    logic [c_BAUD_W-1:0] r_baud;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_shift;
    logic                r_txd;

    state_t              w_state_nxt;
    logic [c_BAUD_W-1:0] w_baud_nxt;
    logic [2:0]          w_bit_nxt;
    logic [7:0]          w_shift_nxt;
    logic                w_txd_nxt;
    logic                w_pop;

    logic w_push_req;
    logic w_clr_req;
    logic w_push;
    logic w_ovf_set;
    logic w_full;
    logic w_busy;

    assign w_push_req = bus.we && (bus.addr == TX_ADDR);
    assign w_clr_req  = bus.we && (bus.addr == STAT_ADDR) && bus.wdata[2];
    assign w_full     = (r_count == c_DEPTH);
    // A full FIFO still accepts a byte when the serialiser drains one in the same cycle.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_ovf_set  = w_push_req && !w_push;
    assign w_busy     = (r_state != ST_IDLE) || (r_count != '0);

    assign bus.busy  = w_busy;
    assign bus.txd   = r_txd;
    assign bus.rdata = (bus.addr == STAT_ADDR) ? {29'b0, r_overflow, w_full, w_busy} : 32'b0;

    // FIFO data write. The storage needs no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.wdata[7:0];
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            // When a drop and a clear land in the same cycle, the drop is kept visible.
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (w_clr_req) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Serialiser state register. txd is registered so the line is glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_txd     <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_baud    <= w_baud_nxt;
            r_bit_idx <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_txd     <= w_txd_nxt;
        end
    end

    // Serialiser next-state logic. txd_nxt is the line level for the cycle after the edge.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_txd_nxt   = r_txd;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_txd_nxt = 1'b1;
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = r_mem[r_rd_ptr];
                    w_baud_nxt  = '0;
                    w_state_nxt = ST_START;
                    w_txd_nxt   = 1'b0;
                end
            end
            ST_START: begin
                if (r_baud == c_BAUD_LAST) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = ST_DATA;
                    w_txd_nxt   = r_shift[0];
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            ST_DATA: begin
                if (r_baud == c_BAUD_LAST) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = ST_STOP;
                        w_txd_nxt   = 1'b1;
                    end else begin
                        w_bit_nxt = r_bit_idx + 3'd1;
                        w_txd_nxt = r_shift[1];
                    end
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            ST_STOP: begin
                if (r_baud == c_BAUD_LAST) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = ST_IDLE;
                    w_txd_nxt   = 1'b1;
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_txd_nxt   = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_tx_mmio
// Description : Self-checking bench for uart_tx_mmio.
//               A transaction-level model of the queue and frame timing runs alongside the DUT.
//               A line receiver decodes every frame on txd.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_mmio;

    localparam int          CPB   = 4;
    localparam int          DEPTH = 8;
    localparam int          FRAME = 10 * CPB;
    localparam logic [31:0] TX    = 32'h0000_F000;
    localparam logic [31:0] STAT  = 32'h0000_F004;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_tx_mmio_if bus ();

    uart_tx_mmio #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .TX_ADDR      (TX),
        .STAT_ADDR    (STAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    // m_cyc is the index of the next edge.
    // A frame popped at edge P occupies edges P..P+FRAME-1.
    // The next pop is possible at edge P+FRAME+1.
    int         m_cyc     = 0;
    int         m_free_at = 0;
    int         m_pop_cyc = 0;
    logic [7:0] m_cur     = 8'h00;
    bit         m_ovf     = 1'b0;
    logic [7:0] mq[$];
    logic [7:0] exp_line[$];

    // Bytes decoded from txd
    logic [7:0] rx_q[$];
    int         frame_err = 0;

    function automatic bit m_active();
        return m_cyc < m_free_at;
    endfunction

    function automatic bit m_busy();
        return m_active() || (mq.size() != 0);
    endfunction

    function automatic logic m_txd();
        int k;
        int slot;
        if (!m_active()) return 1'b1;
        k    = m_cyc - 1 - m_pop_cyc;
        slot = k / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return m_cur[slot-1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_status();
        return {29'b0, m_ovf, (mq.size() == DEPTH), m_busy()};
    endfunction

    // Advance the model over one edge, using the inputs that the DUT will sample.
    function automatic void model_step();
        bit push_req;
        bit clr;
        bit ovf_set;
        if (rst) begin
            mq.delete();
            exp_line.delete();
            m_ovf     = 1'b0;
            m_free_at = 0;
        end else begin
            push_req = bus.we && (bus.addr == TX);
            clr      = bus.we && (bus.addr == STAT) && bus.wdata[2];
            ovf_set  = 1'b0;
            if (!m_active() && mq.size() != 0) begin
                m_cur     = mq.pop_front();
                exp_line.push_back(m_cur);
                m_pop_cyc = m_cyc;
                m_free_at = m_cyc + FRAME + 1;
            end
            if (push_req) begin
                if (mq.size() < DEPTH) mq.push_back(bus.wdata[7:0]);
                else                   ovf_set = 1'b1;
            end
            if (ovf_set)  m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
        end
        m_cyc++;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus.we    = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        tick();
        bus.we    = 1'b0;
        bus.addr  = STAT;
    endtask

    task automatic wait_idle(input int limit, output bit timed_out);
        int n = 0;
        while (m_busy() && n < limit) begin
            tick();
            n++;
        end
        timed_out = m_busy();
        repeat (3) tick();
    endtask

    // Line receiver: samples each bit at mid-period, and abandons the frame on reset.
    always begin : rx_monitor
        logic [7:0] b;
        bit         ok;
        bit         aborted;
        int         slot;
        @(posedge clk);
        #2;
        if (rst === 1'b0 && bus.txd === 1'b0) begin
            b       = 8'h00;
            ok      = 1'b1;
            aborted = 1'b0;
            for (int k = 1; k < FRAME; k++) begin
                @(posedge clk);
                #2;
                if (rst !== 1'b0) begin
                    aborted = 1'b1;
                    break;
                end
                if (k % CPB == CPB / 2) begin
                    slot = k / CPB;
                    if (slot == 0) begin
                        if (bus.txd !== 1'b0) ok = 1'b0;
                    end else if (slot <= 8) begin
                        b[slot-1] = bus.txd;
                    end else if (bus.txd !== 1'b1) begin
                        ok = 1'b0;
                    end
                end
            end
            if (!aborted) begin
                rx_q.push_back(b);
                if (!ok) frame_err++;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        bus.addr = STAT;
        repeat (3) tick();
        checks++; if (bus.txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b want 1", bus.txd); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL reset_status: got %h want 0", bus.rdata); end
        rst = 1'b0;
        bus.addr = 32'h0000_0000;
        #1;
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata_other: got %h want 0", bus.rdata); end
        tick();
    endtask

    task automatic test_single_frame(input logic [7:0] b);
        logic exp_txd;
        logic [7:0] got;
        store(TX, {$urandom() & 32'hFFFF_FF00} | {24'h0, b});
        checks++; if (bus.busy !== 1'b1 || bus.txd !== 1'b1) begin
            errors++; $display("FAIL frame_push_edge: busy=%b txd=%b want busy=1 txd=1", bus.busy, bus.txd);
        end
        for (int k = 0; k <= FRAME; k++) begin
            tick();
            if (k < CPB)            exp_txd = 1'b0;
            else if (k < 9 * CPB)   exp_txd = b[(k - CPB) / CPB];
            else                    exp_txd = 1'b1;
            checks++; if (bus.txd !== exp_txd) begin
                errors++; $display("FAIL frame_txd k=%0d byte=%h: got %b want %b", k, b, bus.txd, exp_txd);
            end
            checks++; if (bus.busy !== (k < FRAME)) begin
                errors++; $display("FAIL frame_busy k=%0d: got %b want %b", k, bus.busy, (k < FRAME));
            end
        end
        tick();
        got = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hxx;
        void'(exp_line.pop_front());
        checks++; if (got !== b) begin errors++; $display("FAIL frame_rx: got %h want %h", got, b); end
    endtask

    task automatic test_overflow();
        bit to;
        for (int i = 0; i < 10; i++) store(TX, i);
        #1;
        checks++; if (bus.rdata !== 32'h7) begin errors++; $display("FAIL ovf_status: got %h want 7", bus.rdata); end
        checks++; if (bus.rdata !== m_status()) begin errors++; $display("FAIL ovf_status_model: got %h want %h", bus.rdata, m_status()); end
        store(STAT, 32'h4);
        #1;
        checks++; if (bus.rdata[2] !== 1'b0 || bus.rdata !== m_status()) begin
            errors++; $display("FAIL ovf_clear: got %h want %h", bus.rdata, m_status());
        end
        wait_idle(2000, to);
        checks++; if (to) begin errors++; $display("FAIL ovf_drain_timeout: got busy want idle"); end
        checks++; if (rx_q.size() != 9) begin errors++; $display("FAIL ovf_rx_count: got %0d want 9", rx_q.size()); end
        for (int i = 0; i < 9 && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== 8'(i)) begin errors++; $display("FAIL ovf_rx_byte %0d: got %h want %h", i, rx_q[i], 8'(i)); end
        end
        checks++; if (frame_err != 0) begin errors++; $display("FAIL ovf_framing: got %0d want 0", frame_err); end
        rx_q.delete();
        exp_line.delete();
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b0;
        bit stayed_high = 1'b1;
        b0 = 8'($urandom());
        store(TX, {24'h0, b0});
        store(TX, $urandom());
        store(TX, $urandom());
        repeat (15) tick();
        checks++; if (bus.txd !== b0[3]) begin errors++; $display("FAIL rstmid_bit3: got %b want %b", bus.txd, b0[3]); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.txd !== 1'b1 || bus.busy !== 1'b0 || bus.rdata !== 32'h0) begin
            errors++; $display("FAIL rstmid_state: txd=%b busy=%b status=%h want 1 0 0", bus.txd, bus.busy, bus.rdata);
        end
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            if (bus.txd !== 1'b1) stayed_high = 1'b0;
        end
        checks++; if (!stayed_high || rx_q.size() != 0) begin
            errors++; $display("FAIL rstmid_quiet: high=%b rx=%0d want 1 0", stayed_high, rx_q.size());
        end
    endtask

    task automatic test_ignored();
        store(32'h0000_F008, $urandom());
        bus.we = 1'b0; bus.addr = TX; bus.wdata = $urandom();
        tick();
        bus.addr = STAT;
        repeat (2) tick();
        checks++; if (bus.busy !== 1'b0 || bus.txd !== 1'b1) begin
            errors++; $display("FAIL ignored_line: busy=%b txd=%b want 0 1", bus.busy, bus.txd);
        end
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL ignored_status: got %h want 0", bus.rdata); end
    endtask

    task automatic test_push_pop_full();
        logic [7:0] sent[$];
        logic [7:0] v;
        int n = 0;
        bit to;
        for (int i = 0; i < 9; i++) begin
            v = 8'($urandom());
            sent.push_back(v);
            store(TX, {24'h0, v});
        end
        #1;
        checks++; if (bus.rdata !== 32'h3) begin errors++; $display("FAIL ppf_full: got %h want 3", bus.rdata); end
        while ((m_active() || mq.size() == 0) && n < 200) begin
            tick();
            n++;
        end
        v = 8'($urandom());
        sent.push_back(v);
        store(TX, {24'h0, v});
        #1;
        checks++; if (bus.rdata !== 32'h3) begin errors++; $display("FAIL ppf_accept: got %h want 3", bus.rdata); end
        wait_idle(2000, to);
        checks++; if (to || rx_q.size() != 10) begin
            errors++; $display("FAIL ppf_rx_count: got %0d want 10", rx_q.size());
        end
        for (int i = 0; i < 10 && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== sent[i]) begin errors++; $display("FAIL ppf_rx_byte %0d: got %h want %h", i, rx_q[i], sent[i]); end
        end
        rx_q.delete();
        exp_line.delete();
    endtask

    task automatic test_random();
        int r;
        bit to;
        logic [31:0] exp_rd;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 3);
            bus.we    = ($urandom_range(0, 2) == 0);
            bus.addr  = (r < 2) ? TX : (r == 2) ? STAT : (($urandom_range(0, 1) == 0) ? 32'h0000_F008 : $urandom());
            bus.wdata = $urandom();
            #1;
            exp_rd = (bus.addr == STAT) ? m_status() : 32'h0;
            checks++; if (bus.rdata !== exp_rd) begin errors++; $display("FAIL rand_rdata cyc=%0d: got %h want %h", i, bus.rdata, exp_rd); end
            tick();
            checks++; if (bus.txd !== m_txd()) begin errors++; $display("FAIL rand_txd cyc=%0d: got %b want %b", i, bus.txd, m_txd()); end
            checks++; if (bus.busy !== m_busy()) begin errors++; $display("FAIL rand_busy cyc=%0d: got %b want %b", i, bus.busy, m_busy()); end
        end
        bus.we = 1'b0;
        bus.addr = STAT;
        wait_idle(20000, to);
        checks++; if (to || rx_q.size() != exp_line.size()) begin
            errors++; $display("FAIL rand_rx_count: got %0d want %0d", rx_q.size(), exp_line.size());
        end
        for (int i = 0; i < rx_q.size() && i < exp_line.size(); i++) begin
            checks++; if (rx_q[i] !== exp_line[i]) begin errors++; $display("FAIL rand_rx_byte %0d: got %h want %h", i, rx_q[i], exp_line[i]); end
        end
        checks++; if (frame_err != 0) begin errors++; $display("FAIL rand_framing: got %0d want 0", frame_err); end
    endtask

    initial begin
        bus.we    = 1'b0;
        bus.addr  = 32'h0;
        bus.wdata = 32'h0;
        test_reset();
        test_single_frame(8'h55);
        test_single_frame(8'($urandom()));
        test_overflow();
        test_reset_mid_frame();
        test_ignored();
        test_push_pop_full();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
